// File: rtl/bit_serializer.sv
// ============================================================================
// Module   : bit_serializer
// Purpose  : Accepts a WIDTH-bit parallel word through a valid/ready handshake
//            and shifts it out MSB first on a registered serial output. A word
//            offered on the last-bit edge is loaded immediately, so consecutive
//            words stream with no gap.
// Revision : 1.0 - initial release
//
// Parameters
//   WIDTH      data word width in bits (2..32)
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   din        parallel word to serialize
//   din_valid  din holds a word offered for transfer
//   din_ready  word accepted on this edge when din_valid is also high
//   en         bit-advance enable; low stalls the output stream
//   d_out      serial bit, MSB first, registered
//   d_valid    d_out carries a valid stream bit this cycle
//   busy       FSM is not IDLE
//
// Build option
//   SER_PARITY_EN  when defined, each word is followed by one even-parity bit
//                  (XOR of the captured word) emitted from a PARITY state.
// ============================================================================
`default_nettype none

module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             en,
  output logic             d_out,
  output logic             d_valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_CNT_MAX = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif
  logic             ready_w;
  logic             last_edge_w;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
`ifdef SER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
`ifdef SER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    dout_d      = dout_q;
    dvalid_d    = dvalid_q;
`ifdef SER_PARITY_EN
    par_d       = par_q;
`endif
    ready_w     = 1'b0;
    last_edge_w = 1'b0;

    case (state_q)
      IDLE: begin
        ready_w  = 1'b1;
        dout_d   = 1'b0;
        dvalid_d = 1'b0;
      end

      SHIFT: begin
        if (en) begin
          if (cnt_q == C_CNT_MAX) begin
`ifdef SER_PARITY_EN
            state_d = PARITY;
            dout_d  = par_q;
`else
            last_edge_w = 1'b1;
            ready_w     = 1'b1;
`endif
          end else begin
            // sr_q already holds the word shifted past the bit on d_out,
            // so its MSB is the next bit to present.
            cnt_d  = cnt_q + CW'(1);
            dout_d = sr_q[WIDTH-1];
            sr_d   = {sr_q[WIDTH-2:0], 1'b0};
          end
        end
      end

`ifdef SER_PARITY_EN
      PARITY: begin
        if (en) begin
          last_edge_w = 1'b1;
          ready_w     = 1'b1;
        end
      end
`endif

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        dout_d   = 1'b0;
        dvalid_d = 1'b0;
      end
    endcase

    // End of word with nothing waiting: fall back to IDLE.
    if (last_edge_w) begin
      state_d  = IDLE;
      cnt_d    = '0;
      dout_d   = 1'b0;
      dvalid_d = 1'b0;
    end

    // Transfer overrides the end-of-word path, giving back-to-back streaming.
    // The MSB goes straight to d_out; the register keeps the remaining bits.
    if (din_valid && ready_w) begin
      state_d  = SHIFT;
      cnt_d    = '0;
      sr_d     = {din[WIDTH-2:0], 1'b0};
      dout_d   = din[WIDTH-1];
      dvalid_d = 1'b1;
`ifdef SER_PARITY_EN
      par_d    = ^din;
`endif
    end
  end

  assign din_ready = ready_w;
  assign d_out     = dout_q;
  assign d_valid   = dvalid_q;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bit_serializer.sv
// ============================================================================
// Module   : tb_bit_serializer
// Purpose  : Self-checking bench for bit_serializer. The driver pushes the
//            expected serial bits of every offered word into a queue; a
//            monitor on the falling edge compares each valid output bit
//            against the queue head and pops it when the stream advances.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serializer;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         en;
  logic         d_out;
  logic         d_valid;
  logic         busy;

  bit_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .en        (en),
    .d_out     (d_out),
    .d_valid   (d_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   exp_q[$];
  int   run_len = 0;
  int   last_run = 0;
  int   det_cnt = 0;
  logic [1:0] hist = 2'b00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every valid bit; pop only when the stream advances.
  always @(negedge clk) begin
    bit b;
    if (rst) begin
      run_len = 0;
    end else if (d_valid) begin
      run_len++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL stream: got bit %0b expected no valid bit (t=%0t)", d_out, $time);
      end else begin
        chk("stream_bit", {31'b0, d_out}, {31'b0, exp_q[0]});
        if (en) begin
          b = exp_q.pop_front();
          if ({hist, b} == 3'b110) det_cnt++;
          hist = {hist[0], b};
        end
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  // Offer one word, push its expected bits, wait for the transfer edge.
  // waits returns the number of edges taken until acceptance.
  task automatic offer(input logic [W-1:0] w, output int waits);
    bit acc;
    bit got;
    din       = w;
    din_valid = 1'b1;
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef SER_PARITY_EN
    exp_q.push_back(^w);
`endif
    got   = 1'b0;
    waits = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      acc = din_ready;
      @(posedge clk);
      #1;
      waits++;
      if (acc) got = 1'b1;
    end
    din_valid = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no transfer expected transfer of %0h", w);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (!busy && !d_valid) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
    @(negedge clk);
  endtask

  initial begin
    int wt;

    // Reset with a pending word: must be ignored.
    rst = 1'b1; en = 1'b1; din = 8'hA5; din_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    chk("rst_d_valid",   {31'b0, d_valid},   32'd0);
    chk("rst_d_out",     {31'b0, d_out},     32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_din_ready", {31'b0, din_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Single word B6, exact length and idle afterwards.
    offer(8'hB6, wt);
    chk("idle_accept_wait", wt, 32'd1);
    repeat (NB) @(posedge clk);
    @(negedge clk);
    chk("b6_end_d_valid",   {31'b0, d_valid},   32'd0);
    chk("b6_end_din_ready", {31'b0, din_ready}, 32'd1);
    chk("b6_end_busy",      {31'b0, busy},      32'd0);
    @(negedge clk);
    chk("b6_run_len", last_run, NB);

    // Back-to-back C3 then 5A with no gap.
    @(posedge clk);
    #1;
    offer(8'hC3, wt);
    offer(8'h5A, wt);
    chk("b2b_accept_wait", wt, NB);
    wait_idle();
    chk("b2b_run_len", last_run, 2 * NB);

    // Stall for 3 cycles while bit 3 of B6 is on the output.
    @(posedge clk);
    #1;
    offer(8'hB6, wt);
    repeat (3) @(posedge clk);
    #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    repeat (NB - 3) @(posedge clk);
    @(negedge clk);
    chk("stall_end_d_valid", {31'b0, d_valid}, 32'd0);
    @(negedge clk);
    chk("stall_run_len", last_run, NB + 3);

    // Reset while bit 4 of FF is on the output.
    @(posedge clk);
    #1;
    offer(8'hFF, wt);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_d_out",     {31'b0, d_out},     32'd0);
    chk("midrst_d_valid",   {31'b0, d_valid},   32'd0);
    chk("midrst_busy",      {31'b0, busy},      32'd0);
    chk("midrst_din_ready", {31'b0, din_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("midrst_stays_idle", {31'b0, busy}, 32'd0);

    // Parity words (parity bits pushed only in the parity build).
    @(posedge clk);
    #1;
    offer(8'h07, wt);
    offer(8'h03, wt);
    wait_idle();
    chk("par_run_len", last_run, 2 * NB);

    // 00000110 contains the pattern 1-1-0 exactly once.
    hist = 2'b00;
    det_cnt = 0;
    @(posedge clk);
    #1;
    offer(8'h06, wt);
    wait_idle();
    chk("det110_count", det_cnt, 32'd1);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
